mac_vec_engine: RTL and testbench

Parametrised multi-lane multiply-accumulate engine and the successor to the single-lane MAC. It has LANES independent accumulators that each sum a[i]*b[i] over a programmed number of beats. It supports signed/unsigned operands and saturating/wrapping accumulation. Operands arrive on a valid/ready stream and results leave through a held valid/ready output. It sits between the operand fetch logic and the result writeback in the matrix-multiply datapath.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/mac_lane.sv | 67 ++++++
 rtl/mac_vec_engine.sv | 108 ++++++++++
 tb/tb_mac_vec_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC engine: FSM state encoding,
// product-width rule and the saturation limits used by every lane.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    // Widest accumulator the limit helpers can describe; callers cast down to their width.
    localparam int LIMIT_W = 128;

    // Full-precision product width for a DATA_WIDTH x DATA_WIDTH multiply.
    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic logic [LIMIT_W-1:0] max_unsigned(input int width);
        return {LIMIT_W{1'b1}} >> (LIMIT_W - width);
    endfunction

    function automatic logic [LIMIT_W-1:0] max_signed(input int width);
        return {LIMIT_W{1'b1}} >> (LIMIT_W - width + 1);
    endfunction

    function automatic logic [LIMIT_W-1:0] min_signed(input int width);
        return {{(LIMIT_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: a*b extended to ACC_WIDTH+1, added to the accumulator, with
// overflow detection, saturate/wrap selection and a sticky overflow flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  is_signed,
    input  logic                  sat,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  ovf
);

    localparam int PROD_WIDTH = prod_width(DATA_WIDTH);
    localparam logic [ACC_WIDTH-1:0] ACC_UMAX = ACC_WIDTH'(max_unsigned(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_SMAX = ACC_WIDTH'(max_signed(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_SMIN = ACC_WIDTH'(min_signed(ACC_WIDTH));

    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]    prod_ext;
    logic [ACC_WIDTH:0]    acc_ext;
    logic [ACC_WIDTH:0]    sum;
    logic                  sum_ovf;
    logic [ACC_WIDTH-1:0]  acc_next;

    // The low PROD_WIDTH bits of the product of the extended operands are exact
    // for both signed and unsigned interpretation.
    always_comb begin
        a_ext    = {{DATA_WIDTH{is_signed & a[DATA_WIDTH-1]}}, a};
        b_ext    = {{DATA_WIDTH{is_signed & b[DATA_WIDTH-1]}}, b};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_WIDTH + 1 - PROD_WIDTH){is_signed & prod[PROD_WIDTH-1]}}, prod};
        acc_ext  = {is_signed & acc[ACC_WIDTH-1], acc};
        sum      = acc_ext + prod_ext;
        sum_ovf  = is_signed ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];

        acc_next = sum[ACC_WIDTH-1:0];
        if (sum_ovf && sat) begin
            if (!is_signed)
                acc_next = ACC_UMAX;
            else
                acc_next = sum[ACC_WIDTH] ? ACC_SMIN : ACC_SMAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= acc_next;
            ovf <= ovf | sum_ovf;
        end
    end

endmodule

// File: rtl/mac_vec_engine.sv
// Multi-lane dot-product engine: IDLE/ACCUM/DONE control, beat counter and
// per-job config latches driving LANES independent mac_lane instances.
module mac_vec_engine
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic                        cfg_signed,
    input  logic                        cfg_sat,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_vec,
    input  logic [LANES*DATA_WIDTH-1:0] b_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*ACC_WIDTH-1:0]  out_acc,
    output logic [LANES-1:0]            out_ovf,
    output logic                        busy
);

    mac_state_e           state;
    mac_state_e           next_state;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 signed_q;
    logic                 sat_q;
    logic                 job_start;
    logic                 beat;

    assign job_start = (state == IDLE) && start;
    assign beat      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len != '0) ? ACCUM : DONE;
            ACCUM:   if (beat && beat_cnt == LEN_WIDTH'(1)) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else if (job_start) begin
            beat_cnt <= len;
            signed_q <= cfg_signed;
            sat_q    <= cfg_sat;
        end else if (beat) begin
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
        end
    end

    // Lane registers hold their value outside ACCUM, so out_acc stays stable in DONE and IDLE.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear     (job_start),
            .en        (beat),
            .is_signed (signed_q),
            .sat       (sat_q),
            .a         (a_vec[i*DATA_WIDTH +: DATA_WIDTH]),
            .b         (b_vec[i*DATA_WIDTH +: DATA_WIDTH]),
            .acc       (out_acc[i*ACC_WIDTH +: ACC_WIDTH]),
            .ovf       (out_ovf[i])
        );
    end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Scoreboard bench for mac_vec_engine: a 24-bit-accumulator instance and a
// 16-bit one; expected results are queued at job issue and popped on handshake.
module tb_mac_vec_engine;

    localparam int DW  = 8;
    localparam int L   = 4;
    localparam int LW  = 8;
    localparam int AWA = 24;
    localparam int AWB = 16;

    typedef struct {
        logic [L-1:0][23:0] acc;
        logic [L-1:0]       ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start_a, start_b, cfg_signed, cfg_sat, in_valid, out_ready;
    logic [LW-1:0]   len;
    logic [L*DW-1:0] a_vec, b_vec;

    logic             in_ready_a, out_valid_a, busy_a;
    logic [L*AWA-1:0] out_acc_a;
    logic [L-1:0]     out_ovf_a;
    logic             in_ready_b, out_valid_b, busy_b;
    logic [L*AWB-1:0] out_acc_b;
    logic [L-1:0]     out_ovf_b;

    mac_vec_engine #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AWA), .LEN_WIDTH(LW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .len(len), .cfg_signed(cfg_signed),
        .cfg_sat(cfg_sat), .in_valid(in_valid), .in_ready(in_ready_a), .a_vec(a_vec),
        .b_vec(b_vec), .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_ovf(out_ovf_a), .busy(busy_a)
    );

    mac_vec_engine #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AWB), .LEN_WIDTH(LW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len), .cfg_signed(cfg_signed),
        .cfg_sat(cfg_sat), .in_valid(in_valid), .in_ready(in_ready_b), .a_vec(a_vec),
        .b_vec(b_vec), .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_ovf(out_ovf_b), .busy(busy_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad   = 0;
    int   ready_cnt_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] v0, v1, v2, v3, input logic [3:0] ovf);
        exp_t e;
        e.acc[0] = v0;
        e.acc[1] = v1;
        e.acc[2] = v2;
        e.acc[3] = v3;
        e.ovf    = ovf;
        return e;
    endfunction

    function automatic logic [31:0] pack4(input int x0, x1, x2, x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    // Monitors: compare each result on the cycle its handshake completes.
    always @(negedge clk) begin
        if (out_valid_a && out_ready) begin
            if (q_a.size() == 0) begin
                check("unexpected_result_a", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                for (int i = 0; i < L; i++)
                    check($sformatf("acc_a_lane%0d", i), 32'(out_acc_a[i*AWA +: AWA]), 32'(ea.acc[i]));
                check("ovf_a", 32'(out_ovf_a), 32'(ea.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                check("unexpected_result_b", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                for (int i = 0; i < L; i++)
                    check($sformatf("acc_b_lane%0d", i), 32'(out_acc_b[i*AWB +: AWB]), 32'(eb.acc[i][15:0]));
                check("ovf_b", 32'(out_ovf_b), 32'(eb.ovf));
            end
        end
    end

    always @(negedge clk) if (in_ready_a) ready_cnt_a++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input bit on_b, input int n, input bit sgn, input bit sat);
        len        = LW'(n);
        cfg_signed = sgn;
        cfg_sat    = sat;
        if (on_b) start_b = 1'b1;
        else      start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_beat(input bit on_b, input logic [31:0] av, input logic [31:0] bv);
        bit ok = 1'b0;
        a_vec    = av;
        b_vec    = bv;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ok = on_b ? in_ready_b : in_ready_a;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    // Reports how many negedges elapsed before the result handshake was seen.
    task automatic wait_result(input bit on_b, input int exp_wait, input string name);
        bit seen = 1'b0;
        int c;
        for (c = 0; c < 50; c++) begin
            @(negedge clk);
            seen = on_b ? (out_valid_b && out_ready) : (out_valid_a && out_ready);
            tick();
            if (seen) break;
        end
        check(name, seen ? 32'(c) : 32'd999, 32'(exp_wait));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int snap;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; len = '0; cfg_signed = 1'b0; cfg_sat = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a_vec = '0; b_vec = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_acc_zero", 32'(|out_acc_a), 32'd0);
        check("rst_ovf", 32'(out_ovf_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Unsigned len=3: 255*255*3 = 195075 in lane 0, 1*2*3 = 6 elsewhere.
        q_a.push_back(mk(24'h02FA03, 24'd6, 24'd6, 24'd6, 4'b0000));
        start_job(0, 3, 0, 0);
        check("t1_busy", 32'(busy_a), 32'd1);
        for (int k = 0; k < 3; k++) send_beat(0, pack4(255, 1, 1, 1), pack4(255, 2, 2, 2));
        wait_result(0, 0, "t1_latency");

        // Signed len=2: -128*127*2 = -32512; lanes 1-3 1*(-1)*2 = -2.
        q_a.push_back(mk(24'hFF8100, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFE, 4'b0000));
        start_job(0, 2, 1, 0);
        for (int k = 0; k < 2; k++) send_beat(0, pack4(8'h80, 1, 1, 1), pack4(8'h7F, 8'hFF, 8'hFF, 8'hFF));
        wait_result(0, 0, "t2_latency");

        // 16-bit accumulator, 2 x 65025 = 130050 overflows: saturate, then wrap.
        q_b.push_back(mk(24'h00FFFF, 24'd0, 24'd0, 24'd0, 4'b0001));
        start_job(1, 2, 0, 1);
        for (int k = 0; k < 2; k++) send_beat(1, pack4(255, 0, 0, 0), pack4(255, 0, 0, 0));
        wait_result(1, 0, "t3_sat_latency");

        q_b.push_back(mk(24'h00FC02, 24'd0, 24'd0, 24'd0, 4'b0001));
        start_job(1, 2, 0, 0);
        for (int k = 0; k < 2; k++) send_beat(1, pack4(255, 0, 0, 0), pack4(255, 0, 0, 0));
        wait_result(1, 0, "t3_wrap_latency");

        // Signed saturation on 16 bits: clamp low, clamp high, clamp then recover.
        q_b.push_back(mk(24'h008000, 24'h007FFF, 24'h00407F, 24'd0, 4'b0111));
        start_job(1, 3, 1, 1);
        send_beat(1, pack4(8'h80, 8'h80, 8'h80, 0), pack4(8'h7F, 8'h80, 8'h80, 0));
        send_beat(1, pack4(8'h80, 8'h80, 8'h80, 0), pack4(8'h7F, 8'h80, 8'h80, 0));
        send_beat(1, pack4(8'h80, 8'h80, 8'h80, 0), pack4(8'h7F, 8'h80, 8'h7F, 0));
        wait_result(1, 0, "t3_ssat_latency");

        // Backpressure: idle gaps carrying junk operands, then a stalled consumer.
        q_a.push_back(mk(24'd100, 24'd200, 24'd300, 24'd400, 4'b0000));
        start_job(0, 4, 0, 0);
        for (int k = 0; k < 4; k++) begin
            a_vec    = pack4(99, 99, 99, 99);
            b_vec    = pack4(99, 99, 99, 99);
            in_valid = 1'b0;
            tick();
            if (k == 3) out_ready = 1'b0;
            send_beat(0, pack4(10, 20, 30, 40), pack4(k + 1, k + 1, k + 1, k + 1));
        end
        for (int j = 0; j < 5; j++) begin
            start_a = (j == 2);
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", j), 32'(out_valid_a), 32'd1);
            check($sformatf("bp_hold_lane0_%0d", j), 32'(out_acc_a[0 +: AWA]), 32'd100);
            check($sformatf("bp_hold_lane3_%0d", j), 32'(out_acc_a[3*AWA +: AWA]), 32'd400);
            tick();
        end
        start_a   = 1'b1;
        out_ready = 1'b1;
        wait_result(0, 0, "bp_handshake");
        start_a = 1'b0;
        @(negedge clk);
        check("bp_idle_busy", 32'(busy_a), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready_a), 32'd0);
        tick();

        // len=0: result on the next cycle, accumulators cleared, no beat ever requested.
        snap = ready_cnt_a;
        q_a.push_back(mk(24'd0, 24'd0, 24'd0, 24'd0, 4'b0000));
        start_job(0, 0, 0, 0);
        wait_result(0, 0, "len0_latency");
        check("len0_no_in_ready", 32'(ready_cnt_a - snap), 32'd0);

        // Reset mid-job after 2 of 5 beats, then a fresh single-beat job.
        start_job(0, 5, 0, 0);
        send_beat(0, pack4(7, 7, 7, 7), pack4(9, 9, 9, 9));
        send_beat(0, pack4(7, 7, 7, 7), pack4(9, 9, 9, 9));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready_a), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_acc_zero", 32'(|out_acc_a), 32'd0);
        tick();
        q_a.push_back(mk(24'd12, 24'd12, 24'd12, 24'd12, 4'b0000));
        start_job(0, 1, 0, 0);
        send_beat(0, pack4(3, 3, 3, 3), pack4(4, 4, 4, 4));
        wait_result(0, 0, "post_rst_latency");

        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
